jt12_opctl: RTL and testbench

// Per-operator control block of the JT12 FM core: holds operator parameters for all slots in a 44-bit circulating CSR ring.

---
 rtl/jt12_opctl_pkg.sv | 62 ++++++
 rtl/jt12_opctl_seg.sv | 54 +++++
 rtl/jt12_opctl.sv | 158 +++++++++++++++
 tb/tb_jt12_opctl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt12_opctl_pkg.sv
// Shared definitions for the JT12 operator control block: the 44-bit CSR word
// layout, slot encodings and the register-group strobe bundle.
package jt12_opctl_pkg;

  localparam int SEG_LEN   = 12;
  localparam int TL_W      = 7;
  localparam int DT1_W     = 3;
  localparam int MUL_W     = 4;
  localparam int KS_W      = 2;
  localparam int AR_W      = 5;
  localparam int D1R_W     = 5;
  localparam int D2R_W     = 5;
  localparam int SL_W      = 4;
  localparam int RR_W      = 4;
  localparam int SSG_EG_W  = 3;
  localparam int CSR_W     = TL_W + DT1_W + MUL_W + KS_W + AR_W + 1 + D1R_W + D2R_W
                           + SL_W + RR_W + 1 + SSG_EG_W;

  // Field order is MSB first, matching the packed ring word.
  typedef struct packed {
    logic [TL_W-1:0]     tl;
    logic [DT1_W-1:0]    dt1;
    logic [MUL_W-1:0]    mul;
    logic [KS_W-1:0]     ks;
    logic [AR_W-1:0]     ar;
    logic                amsen;
    logic [D1R_W-1:0]    d1r;
    logic [D2R_W-1:0]    d2r;
    logic [SL_W-1:0]     sl;
    logic [RR_W-1:0]     rr;
    logic                ssg_en;
    logic [SSG_EG_W-1:0] ssg_eg;
  } op_csr_t;

  typedef enum logic [1:0] {
    SLOT_S1 = 2'd0,
    SLOT_S3 = 2'd1,
    SLOT_S2 = 2'd2,
    SLOT_S4 = 2'd3
  } slot_op_e;

  typedef struct packed {
    logic tl;
    logic dt1;
    logic ks_ar;
    logic amen_dr;
    logic sr;
    logic sl_rr;
    logic ssgeg;
  } reg_up_t;

  // Key-on register bit that belongs to a given operator slot.
  function automatic logic keyon_din_bit(input logic [7:0] din, input logic [1:0] op);
    case (op)
      SLOT_S1: return din[4];
      SLOT_S3: return din[6];
      SLOT_S2: return din[5];
      default: return din[7];
    endcase
  endfunction

endpackage

// File: rtl/jt12_opctl_seg.sv
// One 12-stage segment of the operator CSR ring, with the register-write merge
// applied to the word entering the segment.
module jt12_opctl_seg
  import jt12_opctl_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    clk_en,
  input  logic [7:0] din,
  input  reg_up_t up,
  input  logic    upd_I,
  input  logic    upd_II,
  input  logic    upd_IV,
  input  op_csr_t prev,
  output op_csr_t last
);

  op_csr_t merged;
  op_csr_t [SEG_LEN-1:0] stages;

  always_comb begin
    // NOTE: merged starts as a copy of prev so every path assigns it; no latch is inferred.
    merged = prev;
    if (up.tl      && upd_IV) merged.tl    = din[6:0];
    if (up.dt1     && upd_I ) merged.dt1   = din[6:4];
    if (up.dt1     && upd_II) merged.mul   = din[3:0];
    if (up.ks_ar   && upd_II) merged.ks    = din[7:6];
    if (up.ks_ar   && upd_I ) merged.ar    = din[4:0];
    if (up.amen_dr && upd_IV) merged.amsen = din[7];
    if (up.amen_dr && upd_I ) merged.d1r   = din[4:0];
    if (up.sr      && upd_I ) merged.d2r   = din[4:0];
    if (up.sl_rr   && upd_I ) begin
      merged.sl = din[7:4];
      merged.rr = din[3:0];
    end
    if (up.ssgeg   && upd_I ) begin
      merged.ssg_en = din[3];
      merged.ssg_eg = din[2:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages shift from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the whole storage array is reset because every stage is visible at the ring output.
      stages <= '0;
    end else if (clk_en) begin
      stages <= {stages[SEG_LEN-2:0], merged};
    end
  end

  assign last = stages[SEG_LEN-1];

endmodule

// File: rtl/jt12_opctl.sv
// JT12 per-operator control: circulating CSR ring, per-slot key-on ring with
// CSM timer-A key-on, and algorithm/stage modulation operand decode.
module jt12_opctl
  import jt12_opctl_pkg::*;
#(
  parameter int num_ch = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [7:0] din,
  input  logic       up_tl,
  input  logic       up_dt1,
  input  logic       up_ks_ar,
  input  logic       up_amen_dr,
  input  logic       up_sr,
  input  logic       up_sl_rr,
  input  logic       up_ssgeg,
  input  logic       update_op_I,
  input  logic       update_op_II,
  input  logic       update_op_IV,
  input  logic       up_midop_I,
  input  logic       up_midop_II,
  input  logic       up_midop_IV,
  input  logic       up_keyon,
  input  logic [1:0] next_op,
  input  logic [2:0] next_ch,
  input  logic       csm,
  input  logic       overflow_A,
  input  logic [2:0] alg_I,
  input  logic [1:0] cur_op,
  output logic [6:0] tl_IV,
  output logic [2:0] dt1_I,
  output logic [3:0] mul_II,
  output logic [1:0] ks_II,
  output logic [4:0] ar_I,
  output logic       amsen_IV,
  output logic [4:0] d1r_I,
  output logic [4:0] d2r_I,
  output logic [3:0] sl_I,
  output logic [3:0] rr_I,
  output logic       ssg_en_I,
  output logic [2:0] ssg_eg_I,
  output logic       keyon_I,
  output logic       xuse_prevprev1,
  output logic       xuse_internal,
  output logic       yuse_internal,
  output logic       xuse_prev2,
  output logic       yuse_prev1,
  output logic       yuse_prev2
);

  localparam int N_SLOTS = 4 * num_ch;
  localparam int CNT_W   = $clog2(N_SLOTS);

  reg_up_t up;
  op_csr_t ring_out;

  assign up = '{tl: up_tl, dt1: up_dt1, ks_ar: up_ks_ar, amen_dr: up_amen_dr,
                sr: up_sr, sl_rr: up_sl_rr, ssgeg: up_ssgeg};

  generate
    if (num_ch == 6) begin : g_two_seg
      op_csr_t seg0_out, seg1_out;

      jt12_opctl_seg u_seg0 (
        .clk, .rst, .clk_en, .din, .up,
        .upd_I (update_op_I), .upd_II(update_op_II), .upd_IV(update_op_IV),
        .prev  (seg1_out),    .last  (seg0_out)
      );

      jt12_opctl_seg u_seg1 (
        .clk, .rst, .clk_en, .din, .up,
        .upd_I (up_midop_I),  .upd_II(up_midop_II),  .upd_IV(up_midop_IV),
        .prev  (seg0_out),    .last  (seg1_out)
      );

      assign ring_out = seg1_out;
    end else begin : g_one_seg
      op_csr_t seg0_out;

      jt12_opctl_seg u_seg0 (
        .clk, .rst, .clk_en, .din, .up,
        .upd_I (update_op_I), .upd_II(update_op_II), .upd_IV(update_op_IV),
        .prev  (seg0_out),    .last  (seg0_out)
      );

      assign ring_out = seg0_out;
    end
  endgenerate

  assign tl_IV    = ring_out.tl;
  assign dt1_I    = ring_out.dt1;
  assign mul_II   = ring_out.mul;
  assign ks_II    = ring_out.ks;
  assign ar_I     = ring_out.ar;
  assign amsen_IV = ring_out.amsen;
  assign d1r_I    = ring_out.d1r;
  assign d2r_I    = ring_out.d2r;
  assign sl_I     = ring_out.sl;
  assign rr_I     = ring_out.rr;
  assign ssg_en_I = ring_out.ssg_en;
  assign ssg_eg_I = ring_out.ssg_eg;

  // Key-on ring: the oldest bit is the stored state of the slot entering next cycle.
  logic [N_SLOTS-1:0] kon_ring;
  logic [CNT_W-1:0]   csm_cnt;
  logic               ch_valid;
  logic               kon_hit;
  logic               kon_next;
  logic               csm_trig;
  logic               csm_force;

  always_comb begin
    ch_valid  = (num_ch == 6) ? (din[1:0] != 2'b11) : (din[2:0] < 3'd3);
    kon_hit   = up_keyon && ch_valid && (next_ch == din[2:0]);
    kon_next  = kon_hit ? keyon_din_bit(din, next_op) : kon_ring[N_SLOTS-1];
    csm_trig  = csm && overflow_A;
    csm_force = (csm_trig || (csm_cnt != '0)) && (next_ch == 3'd2);
  end

  // CSM key-on covers the slots entering on the trigger cycle and the N_SLOTS-1 after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kon_ring <= '0;
      keyon_I  <= 1'b0;
      csm_cnt  <= '0;
    end else if (clk_en) begin
      kon_ring <= {kon_ring[N_SLOTS-2:0], kon_next};
      keyon_I  <= kon_next | csm_force;
      if (csm_trig)
        csm_cnt <= CNT_W'(N_SLOTS - 1);
      else if (csm_cnt != '0)
        csm_cnt <= csm_cnt - 1'b1;
    end
  end

  // Modulation operand selects, decoded from algorithm and current stage.
  logic [7:0] h;
  logic       s1, s3, s2, s4;

  always_comb begin
    h  = 8'b1 << alg_I;
    s1 = (cur_op == SLOT_S1);
    s3 = (cur_op == SLOT_S3);
    s2 = (cur_op == SLOT_S2);
    s4 = (cur_op == SLOT_S4);

    xuse_prevprev1 = s1 | (s3 & h[5]);
    xuse_prev2     = (s3 & (h[0] | h[1] | h[2])) | (s4 & h[3]);
    xuse_internal  = s4 & h[2];
    yuse_internal  = s4 & (h[0] | h[1] | h[3] | h[4]);
    yuse_prev1     = s1 | (s3 & h[1]) | (s2 & (h[0] | h[3] | h[4] | h[5] | h[6]))
                   | (s4 & (h[2] | h[5]));
    yuse_prev2     = 1'b0;
  end

endmodule

// File: tb/tb_jt12_opctl.sv
// Directed bench for jt12_opctl (num_ch=6): mod-decode table, CSR write table,
// multi-cycle write/key-on/CSM/reset sequences against a slot counter model.
`timescale 1ns/1ps
module tb_jt12_opctl;
  import jt12_opctl_pkg::*;

  logic clk = 1'b0;
  logic rst, clk_en;
  logic [7:0] din;
  logic up_tl, up_dt1, up_ks_ar, up_amen_dr, up_sr, up_sl_rr, up_ssgeg;
  logic update_op_I, update_op_II, update_op_IV;
  logic up_midop_I, up_midop_II, up_midop_IV;
  logic up_keyon;
  logic [1:0] next_op;
  logic [2:0] next_ch;
  logic csm, overflow_A;
  logic [2:0] alg_I;
  logic [1:0] cur_op;
  logic [6:0] tl_IV;
  logic [2:0] dt1_I;
  logic [3:0] mul_II;
  logic [1:0] ks_II;
  logic [4:0] ar_I;
  logic amsen_IV;
  logic [4:0] d1r_I, d2r_I;
  logic [3:0] sl_I, rr_I;
  logic ssg_en_I;
  logic [2:0] ssg_eg_I;
  logic keyon_I;
  logic xuse_prevprev1, xuse_internal, yuse_internal, xuse_prev2, yuse_prev1, yuse_prev2;

  jt12_opctl #(.num_ch(6)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .din(din),
    .up_tl(up_tl), .up_dt1(up_dt1), .up_ks_ar(up_ks_ar), .up_amen_dr(up_amen_dr),
    .up_sr(up_sr), .up_sl_rr(up_sl_rr), .up_ssgeg(up_ssgeg),
    .update_op_I(update_op_I), .update_op_II(update_op_II), .update_op_IV(update_op_IV),
    .up_midop_I(up_midop_I), .up_midop_II(up_midop_II), .up_midop_IV(up_midop_IV),
    .up_keyon(up_keyon), .next_op(next_op), .next_ch(next_ch),
    .csm(csm), .overflow_A(overflow_A), .alg_I(alg_I), .cur_op(cur_op),
    .tl_IV(tl_IV), .dt1_I(dt1_I), .mul_II(mul_II), .ks_II(ks_II), .ar_I(ar_I),
    .amsen_IV(amsen_IV), .d1r_I(d1r_I), .d2r_I(d2r_I), .sl_I(sl_I), .rr_I(rr_I),
    .ssg_en_I(ssg_en_I), .ssg_eg_I(ssg_eg_I), .keyon_I(keyon_I),
    .xuse_prevprev1(xuse_prevprev1), .xuse_internal(xuse_internal),
    .yuse_internal(yuse_internal), .xuse_prev2(xuse_prev2),
    .yuse_prev1(yuse_prev1), .yuse_prev2(yuse_prev2)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cur      = 0;
  int ch_tab [6] = '{0, 1, 2, 4, 5, 6};
  int kmap   [4] = '{4, 6, 5, 7};
  bit kon_model [24];

  typedef struct {
    logic [6:0]  up;     // {tl, dt1, ks_ar, amen_dr, sr, sl_rr, ssgeg}
    int          stage;  // 0=I, 1=II, 2=IV
    logic [7:0]  din;
    int          slot;
    logic [43:0] exp;
  } csr_vec_t;

  csr_vec_t cv [12];
  logic [5:0] mod_exp [4][8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [43:0] csr(input logic [6:0] tl, input logic [2:0] dt1,
      input logic [3:0] mul, input logic [1:0] ks, input logic [4:0] ar, input logic amsen,
      input logic [4:0] d1r, input logic [4:0] d2r, input logic [3:0] sl, input logic [3:0] rr,
      input logic en, input logic [2:0] eg);
    return {tl, dt1, mul, ks, ar, amsen, d1r, d2r, sl, rr, en, eg};
  endfunction

  function automatic logic [43:0] dut_word();
    return {tl_IV, dt1_I, mul_II, ks_II, ar_I, amsen_IV, d1r_I, d2r_I, sl_I, rr_I,
            ssg_en_I, ssg_eg_I};
  endfunction

  task automatic drive_next();
    int s;
    s = (cur + 1) % 24;
    next_op = 2'(s / 6);
    next_ch = 3'(ch_tab[s % 6]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cur = (cur + 1) % 24;
    drive_next();
  endtask

  task automatic goto(input int s);
    for (int i = 0; i < 24 && cur != s; i++) tick();
  endtask

  task automatic clear_strobes();
    {up_tl, up_dt1, up_ks_ar, up_amen_dr, up_sr, up_sl_rr, up_ssgeg} = '0;
    {update_op_I, update_op_II, update_op_IV} = '0;
    {up_midop_I, up_midop_II, up_midop_IV} = '0;
    up_keyon = 1'b0;
  endtask

  // Hold up_keyon for a full rotation so each slot of the addressed channel passes.
  task automatic keyon_write(input logic [7:0] d);
    din = d;
    up_keyon = 1'b1;
    for (int i = 0; i < 24; i++) begin
      int s, op;
      s  = (cur + 1) % 24;
      op = s / 6;
      if (d[1:0] != 2'b11 && ch_tab[s % 6] == int'(d[2:0]))
        kon_model[s] = d[kmap[op]];
      tick();
    end
    up_keyon = 1'b0;
  endtask

  task automatic keyon_check(input string tag, input bit csm_on);
    for (int i = 0; i < 24; i++) begin
      bit exp;
      tick();
      if (i == 0) overflow_A = 1'b0;
      exp = kon_model[cur] | (csm_on && ch_tab[cur % 6] == 2);
      check($sformatf("%s keyon slot%0d", tag, cur), 64'(keyon_I), 64'(exp));
    end
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; din = '0; csm = 1'b0; overflow_A = 1'b0;
    alg_I = '0; cur_op = '0;
    clear_strobes();
    foreach (kon_model[i]) kon_model[i] = 1'b0;

    // {xuse_prevprev1, xuse_internal, yuse_internal, xuse_prev2, yuse_prev1, yuse_prev2}
    mod_exp[0] = '{6'b100010, 6'b100010, 6'b100010, 6'b100010,
                   6'b100010, 6'b100010, 6'b100010, 6'b100010};
    mod_exp[1] = '{6'b000100, 6'b000110, 6'b000100, 6'b000000,
                   6'b000000, 6'b100000, 6'b000000, 6'b000000};
    mod_exp[2] = '{6'b000010, 6'b000000, 6'b000000, 6'b000010,
                   6'b000010, 6'b000010, 6'b000010, 6'b000000};
    mod_exp[3] = '{6'b001000, 6'b001000, 6'b010010, 6'b001100,
                   6'b001000, 6'b000010, 6'b000000, 6'b000000};

    cv[0]  = '{7'b1000000, 2, 8'hD5, 0,  csr(7'h55,0,0,0,0,0,0,0,0,0,0,0)};
    cv[1]  = '{7'b1000000, 0, 8'hFF, 1,  csr(0,0,0,0,0,0,0,0,0,0,0,0)};
    cv[2]  = '{7'b0010000, 1, 8'hC7, 3,  csr(0,0,0,2'd3,0,0,0,0,0,0,0,0)};
    cv[3]  = '{7'b0010000, 0, 8'hC7, 4,  csr(0,0,0,0,5'h07,0,0,0,0,0,0,0)};
    cv[4]  = '{7'b0001000, 2, 8'h9F, 8,  csr(0,0,0,0,0,1'b1,0,0,0,0,0,0)};
    cv[5]  = '{7'b0001000, 0, 8'h9F, 7,  csr(0,0,0,0,0,0,5'h1F,0,0,0,0,0)};
    cv[6]  = '{7'b0000100, 0, 8'hF3, 9,  csr(0,0,0,0,0,0,0,5'h13,0,0,0,0)};
    cv[7]  = '{7'b0000010, 0, 8'h7E, 10, csr(0,0,0,0,0,0,0,0,4'h7,4'hE,0,0)};
    cv[8]  = '{7'b0000001, 0, 8'h0D, 12, csr(0,0,0,0,0,0,0,0,0,0,1'b1,3'd5)};
    cv[9]  = '{7'b0100000, 0, 8'h37, 13, csr(0,3'd3,0,0,0,0,0,0,0,0,0,0)};
    cv[10] = '{7'b0100000, 1, 8'h37, 15, csr(0,0,4'h7,0,0,0,0,0,0,0,0,0)};
    cv[11] = '{7'b0000001, 2, 8'hFF, 16, csr(0,0,0,0,0,0,0,0,0,0,0,0)};

    cur = 23;
    drive_next();
    repeat (3) @(posedge clk);
    #1;
    check("reset word", 64'(dut_word()), 64'h0);
    check("reset keyon", 64'(keyon_I), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int op = 0; op < 4; op++) begin
      for (int a = 0; a < 8; a++) begin
        cur_op = 2'(op);
        alg_I  = 3'(a);
        #1;
        check($sformatf("mod alg%0d op%0d", a, op),
              64'({xuse_prevprev1, xuse_internal, yuse_internal, xuse_prev2,
                   yuse_prev1, yuse_prev2}), 64'(mod_exp[op][a]));
      end
    end

    goto(0);
    for (int r = 0; r < 24; r++) begin
      foreach (cv[v]) begin
        if (cv[v].slot == cur) begin
          din = cv[v].din;
          {up_tl, up_dt1, up_ks_ar, up_amen_dr, up_sr, up_sl_rr, up_ssgeg} = cv[v].up;
          update_op_I  = (cv[v].stage == 0);
          update_op_II = (cv[v].stage == 1);
          update_op_IV = (cv[v].stage == 2);
        end
      end
      tick();
      clear_strobes();
    end
    for (int r = 0; r < 24; r++) begin
      foreach (cv[v])
        if (cv[v].slot == cur)
          check($sformatf("csr vec%0d slot%0d", v, cur), 64'(dut_word()), 64'(cv[v].exp));
      tick();
    end

    // dt1 at stage I on slot 5, mul at stage II one cycle later on slot 6.
    goto(5);
    din = 8'h5A; up_dt1 = 1'b1; update_op_I = 1'b1;
    tick();
    update_op_I = 1'b0; update_op_II = 1'b1;
    tick();
    clear_strobes();
    goto(4);
    check("dt1 neighbour slot4", 64'(dut_word()), 64'(cv[3].exp));
    tick();
    check("dt1 slot5", 64'(dut_word()), 64'(csr(0,3'b101,0,0,0,0,0,0,0,0,0,0)));
    tick();
    check("mul slot6", 64'(dut_word()), 64'(csr(0,0,4'hA,0,0,0,0,0,0,0,0,0)));

    goto(5);
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("clk_en hold %0d", i), 64'(dt1_I), 64'd5);
    end
    clk_en = 1'b1;
    tick();
    check("clk_en resume slot6", 64'(mul_II), 64'hA);

    // Second ring half: a mid-ring write at head slot 2 lands on slot 14.
    goto(2);
    din = 8'hC3; up_sl_rr = 1'b1; up_midop_I = 1'b1;
    tick();
    clear_strobes();
    goto(14);
    check("midop slot14", 64'(dut_word()), 64'(csr(0,0,0,0,0,0,0,0,4'hC,4'h3,0,0)));
    tick();
    check("midop slot15 kept", 64'(dut_word()), 64'(cv[10].exp));
    goto(2);
    check("midop slot2 kept", 64'(dut_word()), 64'h0);

    keyon_write(8'hF4);
    keyon_check("kon F4", 1'b0);
    keyon_write(8'h51);
    keyon_check("kon 51", 1'b0);
    keyon_write(8'hF3);
    keyon_check("kon F3", 1'b0);
    keyon_write(8'hF7);
    keyon_check("kon F7", 1'b0);
    keyon_write(8'h04);
    keyon_check("kon 04", 1'b0);

    goto(9);
    csm = 1'b1; overflow_A = 1'b1;
    keyon_check("csm on", 1'b1);
    csm = 1'b0;
    keyon_check("csm off", 1'b0);

    // Asynchronous reset mid-rotation at slot 7 (d1r set, key-on set).
    goto(7);
    check("pre-reset word", 64'(dut_word()), 64'(cv[5].exp));
    check("pre-reset keyon", 64'(keyon_I), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async reset word", 64'(dut_word()), 64'h0);
    check("async reset keyon", 64'(keyon_I), 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    foreach (kon_model[i]) kon_model[i] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      check($sformatf("post-reset word %0d", i), 64'(dut_word()), 64'h0);
      check($sformatf("post-reset keyon %0d", i), 64'(keyon_I), 64'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
